// File: rtl/cpu_memory_stage.sv
// Memory pipeline stage: passes ALU results through, runs load/store data-bus accesses,
// and presents a tagged result to writeback with misalignment and bus-timeout faults.
module cpu_memory_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic [7:0]  i_tag,
    input  logic [4:0]  i_inst_rd,
    input  logic [31:0] i_rd,
    input  logic        i_branch,
    input  logic [31:0] i_pc_next,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [31:0] i_mem_address,
    input  logic [1:0]  i_mem_width,
    input  logic        i_mem_signed,
    output logic        o_busy,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic [7:0]  o_tag,
    output logic [4:0]  o_inst_rd,
    output logic [31:0] o_rd,
    output logic        o_branch,
    output logic [31:0] o_pc_next,
    output logic        o_fault
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUS  = 1'b1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [0:0]  state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [7:0]  tag_q, tag_d, lat_tag_q, lat_tag_d;
    logic [4:0]  inst_rd_q, inst_rd_d, lat_rd_q, lat_rd_d;
    logic [31:0] rd_q, rd_d, pc_q, pc_d;
    logic        branch_q, branch_d, fault_q, fault_d;
    logic        req_q, req_d, rw_q, rw_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [1:0]  lat_off_q, lat_off_d, lat_width_q, lat_width_d;
    logic        lat_signed_q, lat_signed_d;

    logic        new_op, is_mem, accept, misaligned;
    logic [1:0]  off;
    logic [31:0] st_data, shifted, ld_data;
    logic [3:0]  st_mask;

    assign off        = i_mem_address[1:0];
    assign new_op     = (i_tag != tag_q);
    assign is_mem     = i_mem_read | i_mem_write;
    assign accept     = (state_q == S_IDLE) && !i_stall && new_op;
    assign o_busy     = (state_q == S_BUS) || ((state_q == S_IDLE) && new_op && is_mem);

    always_comb begin
        misaligned = 1'b0;
        st_data    = i_rd;
        st_mask    = 4'b1111;
        case (i_mem_width)
            2'd0: begin
                st_data = {4{i_rd[7:0]}};
                st_mask = 4'b0001 << off;
            end
            2'd1: begin
                misaligned = off[0];
                st_data    = {2{i_rd[15:0]}};
                st_mask    = 4'b0011 << off;
            end
            default: misaligned = (off != 2'b00);
        endcase
    end

    always_comb begin
        shifted = i_bus_rdata >> {lat_off_q, 3'b000};
        case (lat_width_q)
            2'd0:    ld_data = {{24{lat_signed_q & shifted[7]}}, shifted[7:0]};
            2'd1:    ld_data = {{16{lat_signed_q & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        tag_d        = tag_q;
        inst_rd_d    = inst_rd_q;
        rd_d         = rd_q;
        pc_d         = pc_q;
        branch_d     = branch_q;
        fault_d      = 1'b0;
        req_d        = req_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        lat_tag_d    = lat_tag_q;
        lat_rd_d     = lat_rd_q;
        lat_off_d    = lat_off_q;
        lat_width_d  = lat_width_q;
        lat_signed_d = lat_signed_q;

        if (state_q == S_IDLE) begin
            if (accept) begin
                branch_d = i_branch;
                pc_d     = i_pc_next;
                if (!is_mem) begin
                    rd_d      = i_rd;
                    inst_rd_d = i_inst_rd;
                    tag_d     = i_tag;
                end else if (misaligned) begin
                    fault_d   = 1'b1;
                    inst_rd_d = 5'd0;
                    tag_d     = i_tag;
                end else begin
                    // Clear the destination so nothing forwards a stale value while the bus is busy.
                    inst_rd_d    = 5'd0;
                    lat_tag_d    = i_tag;
                    lat_rd_d     = i_inst_rd;
                    lat_off_d    = off;
                    lat_width_d  = i_mem_width;
                    lat_signed_d = i_mem_signed;
                    req_d        = 1'b1;
                    rw_d         = i_mem_write;
                    addr_d       = {i_mem_address[31:2], 2'b00};
                    wdata_d      = i_mem_write ? st_data : 32'd0;
                    wmask_d      = i_mem_write ? st_mask : 4'b0000;
                    tmo_d        = '0;
                    state_d      = S_BUS;
                end
            end
        end else begin
            if (i_bus_ready) begin
                req_d     = 1'b0;
                tag_d     = lat_tag_q;
                state_d   = S_IDLE;
                if (rw_q) begin
                    inst_rd_d = 5'd0;
                end else begin
                    rd_d      = ld_data;
                    inst_rd_d = lat_rd_q;
                end
            end else if ((TIMEOUT != 0) && (tmo_q == CW'(TIMEOUT - 1))) begin
                req_d     = 1'b0;
                fault_d   = 1'b1;
                inst_rd_d = 5'd0;
                tag_d     = lat_tag_q;
                state_d   = S_IDLE;
            end else if (TIMEOUT != 0) begin
                tmo_d = tmo_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            tag_q        <= 8'd0;
            inst_rd_q    <= 5'd0;
            rd_q         <= 32'd0;
            pc_q         <= 32'd0;
            branch_q     <= 1'b0;
            fault_q      <= 1'b0;
            req_q        <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wmask_q      <= 4'd0;
            lat_tag_q    <= 8'd0;
            lat_rd_q     <= 5'd0;
            lat_off_q    <= 2'd0;
            lat_width_q  <= 2'd0;
            lat_signed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            tag_q        <= tag_d;
            inst_rd_q    <= inst_rd_d;
            rd_q         <= rd_d;
            pc_q         <= pc_d;
            branch_q     <= branch_d;
            fault_q      <= fault_d;
            req_q        <= req_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            lat_tag_q    <= lat_tag_d;
            lat_rd_q     <= lat_rd_d;
            lat_off_q    <= lat_off_d;
            lat_width_q  <= lat_width_d;
            lat_signed_q <= lat_signed_d;
        end
    end

    assign o_tag         = tag_q;
    assign o_inst_rd     = inst_rd_q;
    assign o_rd          = rd_q;
    assign o_branch      = branch_q;
    assign o_pc_next     = pc_q;
    assign o_fault       = fault_q;
    assign o_bus_request = req_q;
    assign o_bus_rw      = rw_q;
    assign o_bus_address = addr_q;
    assign o_bus_wdata   = wdata_q;
    assign o_bus_wmask   = wmask_q;

endmodule

// File: tb/tb_cpu_memory_stage.sv
// Directed bench for cpu_memory_stage: pass-through, loads, stores, misalignment,
// timeout, stall and asynchronous reset, each scenario checking its own expectations.
module tb_cpu_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [7:0]  tag;
    logic [4:0]  inst_rd;
    logic [31:0] rd;
    logic        branch;
    logic [31:0] pc_next;
    logic        mem_read, mem_write;
    logic [31:0] mem_address;
    logic [1:0]  mem_width;
    logic        mem_signed;
    logic        busy, bus_request, bus_rw;
    logic [31:0] bus_address, bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [7:0]  o_tag;
    logic [4:0]  o_inst_rd;
    logic [31:0] o_rd;
    logic        o_branch;
    logic [31:0] o_pc_next;
    logic        o_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_memory_stage #(.TIMEOUT(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_tag(tag),
        .i_inst_rd(inst_rd), .i_rd(rd), .i_branch(branch), .i_pc_next(pc_next),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_address(mem_address),
        .i_mem_width(mem_width), .i_mem_signed(mem_signed), .o_busy(busy),
        .o_bus_request(bus_request), .o_bus_rw(bus_rw), .o_bus_address(bus_address),
        .o_bus_wdata(bus_wdata), .o_bus_wmask(bus_wmask), .i_bus_ready(bus_ready),
        .i_bus_rdata(bus_rdata), .o_tag(o_tag), .o_inst_rd(o_inst_rd), .o_rd(o_rd),
        .o_branch(o_branch), .o_pc_next(o_pc_next), .o_fault(o_fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] t, input logic [4:0] r, input logic [31:0] d,
                          input logic rdf, input logic wrf, input logic [31:0] a,
                          input logic [1:0] w, input logic s);
        tag = t; inst_rd = r; rd = d; mem_read = rdf; mem_write = wrf;
        mem_address = a; mem_width = w; mem_signed = s;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; tag = 8'd0; inst_rd = 5'd0; rd = 32'd0; branch = 1'b0;
        pc_next = 32'd0; mem_read = 1'b0; mem_write = 1'b0; mem_address = 32'd0;
        mem_width = 2'd0; mem_signed = 1'b0; bus_ready = 1'b0; bus_rdata = 32'd0;
        step(); step();
        checks++; if ({o_tag, o_inst_rd, o_rd, o_fault, bus_request, busy} !== 47'd0) begin
            errors++; $display("FAIL reset_outputs: tag=%h rd=%h req=%b", o_tag, o_rd, bus_request); end
        @(negedge clk); rst = 1'b0;
        step();
    endtask

    task automatic test_alu();
        set_op(8'h01, 5'd3, 32'h1111_1111, 1'b0, 1'b0, 32'd0, 2'd2, 1'b0);
        step();
        branch = 1'b1; pc_next = 32'h0000_0400;
        set_op(8'h02, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 2'd2, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alu_busy: got %b want 0", busy); end
        step();
        checks++; if ({o_tag, o_inst_rd, o_rd} !== {8'h02, 5'd5, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL alu_result: tag=%h rd=%0d val=%h", o_tag, o_inst_rd, o_rd); end
        checks++; if ({o_branch, o_pc_next, bus_request} !== {1'b1, 32'h400, 1'b0}) begin
            errors++; $display("FAIL alu_passthru: br=%b pc=%h req=%b", o_branch, o_pc_next, bus_request); end
        branch = 1'b0;
        rd = 32'h0;
        step();
        checks++; if (o_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_hold: got %h want DEADBEEF", o_rd); end
    endtask

    task automatic test_load();
        logic [31:0] want [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011};
        logic [31:0] addr [3] = '{32'h1003, 32'h1003, 32'h1002};
        logic [1:0]  wid  [3] = '{2'd0, 2'd0, 2'd1};
        logic        sgn  [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            set_op(8'h03 + 8'(i), 5'd7, 32'h0, 1'b1, 1'b0, addr[i], wid[i], sgn[i]);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_accept[%0d]: got %b", i, busy); end
            step();
            checks++; if ({bus_request, bus_rw, bus_address, bus_wmask, o_inst_rd} !== {1'b1, 1'b0, 32'h1000, 4'b0, 5'd0}) begin
                errors++; $display("FAIL load_request[%0d]: req=%b rw=%b addr=%h mask=%b rd=%0d", i, bus_request, bus_rw, bus_address, bus_wmask, o_inst_rd); end
            bus_ready = 1'b1; bus_rdata = 32'h8011_2233;
            step();
            bus_ready = 1'b0;
            checks++; if ({bus_request, o_rd, o_inst_rd, o_tag} !== {1'b0, want[i], 5'd7, 8'h03 + 8'(i)}) begin
                errors++; $display("FAIL load_result[%0d]: req=%b val=%h want %h rd=%0d tag=%h", i, bus_request, o_rd, want[i], o_inst_rd, o_tag); end
        end
    endtask

    task automatic test_store();
        int busy_cycles = 0;
        int waited = 0;
        set_op(8'h06, 5'd9, 32'h0000_ABCD, 1'b0, 1'b1, 32'h2002, 2'd1, 1'b0);
        while (busy && waited < 20) begin
            busy_cycles++;
            if (bus_request) waited++;
            if (waited == 3) bus_ready = 1'b1;
            #1;
            if (bus_request) begin
                checks++; if ({bus_rw, bus_address, bus_wdata, bus_wmask} !== {1'b1, 32'h2000, 32'hABCD_ABCD, 4'b1100}) begin
                    errors++; $display("FAIL store_half_bus: rw=%b addr=%h data=%h mask=%b", bus_rw, bus_address, bus_wdata, bus_wmask); end
            end
            step();
            bus_ready = 1'b0;
        end
        checks++; if (busy_cycles !== 4) begin errors++; $display("FAIL store_busy_cycles: got %0d want 4", busy_cycles); end
        checks++; if ({bus_request, o_inst_rd, o_tag} !== {1'b0, 5'd0, 8'h06}) begin
            errors++; $display("FAIL store_done: req=%b rd=%0d tag=%h", bus_request, o_inst_rd, o_tag); end
        set_op(8'h07, 5'd9, 32'h1234_565A, 1'b1, 1'b1, 32'h2001, 2'd0, 1'b0);
        step();
        checks++; if ({bus_request, bus_rw, bus_wdata, bus_wmask} !== {1'b1, 1'b1, 32'h5A5A_5A5A, 4'b0010}) begin
            errors++; $display("FAIL store_byte_bus: req=%b rw=%b data=%h mask=%b", bus_request, bus_rw, bus_wdata, bus_wmask); end
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        checks++; if ({o_tag, o_inst_rd} !== {8'h07, 5'd0}) begin errors++; $display("FAIL store_byte_done: tag=%h rd=%0d", o_tag, o_inst_rd); end
    endtask

    task automatic test_misaligned();
        set_op(8'h08, 5'd4, 32'h0, 1'b1, 1'b0, 32'h3001, 2'd2, 1'b0);
        step();
        checks++; if ({bus_request, o_fault, o_inst_rd, o_tag} !== {1'b0, 1'b1, 5'd0, 8'h08}) begin
            errors++; $display("FAIL misaligned_word: req=%b fault=%b rd=%0d tag=%h", bus_request, o_fault, o_inst_rd, o_tag); end
        step();
        checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL fault_pulse: got %b want 0", o_fault); end
        set_op(8'h09, 5'd4, 32'h0, 1'b0, 1'b1, 32'h3003, 2'd1, 1'b0);
        step();
        checks++; if ({bus_request, o_fault, o_tag} !== {1'b0, 1'b1, 8'h09}) begin
            errors++; $display("FAIL misaligned_half: req=%b fault=%b tag=%h", bus_request, o_fault, o_tag); end
    endtask

    task automatic test_timeout();
        set_op(8'h0A, 5'd2, 32'h0, 1'b1, 1'b0, 32'h4000, 2'd2, 1'b0);
        step(); step(); step(); step();
        checks++; if (bus_request !== 1'b1) begin errors++; $display("FAIL timeout_early: req=%b want 1", bus_request); end
        step();
        checks++; if ({bus_request, o_fault, o_inst_rd, o_tag} !== {1'b0, 1'b1, 5'd0, 8'h0A}) begin
            errors++; $display("FAIL timeout_abort: req=%b fault=%b rd=%0d tag=%h", bus_request, o_fault, o_inst_rd, o_tag); end
        set_op(8'h0B, 5'd2, 32'h0, 1'b1, 1'b0, 32'h4004, 2'd2, 1'b0);
        step(); step(); step(); step();
        bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        bus_ready = 1'b0;
        checks++; if ({o_fault, o_rd, o_inst_rd, o_tag} !== {1'b0, 32'h1234_5678, 5'd2, 8'h0B}) begin
            errors++; $display("FAIL timeout_ready_wins: fault=%b val=%h rd=%0d tag=%h", o_fault, o_rd, o_inst_rd, o_tag); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        set_op(8'h0C, 5'd6, 32'h0000_0C0C, 1'b0, 1'b0, 32'h0, 2'd2, 1'b0);
        step();
        checks++; if (o_tag !== 8'h0B) begin errors++; $display("FAIL stall_hold: tag=%h want 0B", o_tag); end
        stall = 1'b0;
        step();
        checks++; if ({o_tag, o_rd} !== {8'h0C, 32'h0C0C}) begin errors++; $display("FAIL stall_release: tag=%h val=%h", o_tag, o_rd); end
        set_op(8'h0D, 5'd1, 32'h0, 1'b1, 1'b0, 32'h5000, 2'd2, 1'b0);
        step();
        stall = 1'b1; bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
        step();
        bus_ready = 1'b0; stall = 1'b0;
        checks++; if ({o_tag, o_rd, o_inst_rd} !== {8'h0D, 32'hCAFE_F00D, 5'd1}) begin
            errors++; $display("FAIL stall_bus_completes: tag=%h val=%h rd=%0d", o_tag, o_rd, o_inst_rd); end
    endtask

    task automatic test_reset_mid_bus();
        set_op(8'h0E, 5'd3, 32'h0, 1'b1, 1'b0, 32'h6000, 2'd2, 1'b0);
        step();
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus_request, o_tag, o_inst_rd, o_rd} !== 46'd0) begin
            errors++; $display("FAIL reset_mid_bus: req=%b tag=%h rd=%0d val=%h", bus_request, o_tag, o_inst_rd, o_rd); end
        @(negedge clk); rst = 1'b0;
        set_op(8'h0F, 5'd1, 32'h0000_0055, 1'b0, 1'b0, 32'h0, 2'd2, 1'b0);
        step();
        checks++; if ({o_tag, o_rd, o_inst_rd} !== {8'h0F, 32'h55, 5'd1}) begin
            errors++; $display("FAIL after_reset_op: tag=%h val=%h rd=%0d", o_tag, o_rd, o_inst_rd); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_stall();
        test_reset_mid_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
